// File: rtl/uart_rx.sv
// Oversampling UART receiver feeding an RX FIFO write port; optional even parity via
// `define UART_RX_PARITY_EN (adds parity_err_o and a PARITY state).
`timescale 1ns / 1ps

module uart_rx #(
  parameter int unsigned WORD       = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             fifo_full_i,
  input  logic             clr_i,
  output logic [WORD-1:0]  data_o,
  output logic             wr_o,
  output logic             frame_err_o,
  output logic             overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err_o,
`endif
  output logic             busy_o
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(WORD + 1);
  localparam logic [TW-1:0] HalfTick = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LastTick = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LastBit  = BW'(WORD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e           state;
  logic             rx_meta, rx_s;
  logic [DIV_W-1:0] div_cnt, div_lat;
  logic [TW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WORD-1:0]  shift;
  logic             tick;

  assign tick   = (state != StIdle) && (div_cnt == div_lat);
  assign busy_o = (state != StIdle);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= StIdle;
      div_cnt      <= '0;
      div_lat      <= '0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      data_o       <= '0;
      wr_o         <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      wr_o    <= 1'b0;
      div_cnt <= (state == StIdle || tick) ? '0 : div_cnt + 1'b1;

      // Clear first so a set event later in this block takes priority.
      if (clr_i) begin
        frame_err_o  <= 1'b0;
        overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_o <= 1'b0;
`endif
      end

      case (state)
        StIdle: begin
          if (!rx_s) begin
            state    <= StStart;
            tick_cnt <= '0;
            div_lat  <= baud_div_i;
          end
        end
        StStart: begin
          if (tick) begin
            if (tick_cnt == HalfTick) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? StIdle : StData;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (tick_cnt == LastTick) begin
              tick_cnt <= '0;
              shift    <= {rx_s, shift[WORD-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LastBit) begin
`ifdef UART_RX_PARITY_EN
                state <= StParity;
`else
                state <= StStop;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            if (tick_cnt == LastTick) begin
              tick_cnt <= '0;
              if (^{shift, rx_s}) parity_err_o <= 1'b1;
              state <= StStop;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        StStop: begin
          if (tick) begin
            if (tick_cnt == LastTick) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                frame_err_o <= 1'b1;
                state       <= StBreak;
              end else begin
                if (fifo_full_i) begin
                  overrun_o <= 1'b1;
                end else begin
                  data_o <= shift;
                  wr_o   <= 1'b1;
                end
                state <= StIdle;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        // A held-low line reports one framing error, then waits for idle.
        StBreak: begin
          if (rx_s) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
